// File: rtl/spi_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module  : spi_slave_pkg
// Brief   : Opcodes, FSM state encoding and default status ID for spi_slave_regif.
// Revision: 1.0
// ============================================================================
package spi_slave_pkg;

    localparam logic [1:0] OP_NOP    = 2'b00;
    localparam logic [1:0] OP_WRREG  = 2'b01;
    localparam logic [1:0] OP_RDREG  = 2'b10;
    localparam logic [1:0] OP_RDDATA = 2'b11;

    localparam logic [7:0] STATUS_ID_DEF = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CMD       = 3'd1,
        ST_WR_DATA   = 3'd2,
        ST_RD_REG    = 3'd3,
        ST_RD_STREAM = 3'd4,
        ST_DISCARD   = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
// Module  : spi_sync_edge
// Brief   : 2-FF synchroniser for an async pin with rise/fall pulse outputs.
// Revision: 1.0
// ============================================================================
module spi_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= din;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign q    = r_sync;
    assign rise = r_sync & ~r_prev;
    assign fall = ~r_sync & r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_slave_regif.sv
`default_nettype none
// ============================================================================
// Module  : spi_slave_regif
// Brief   : SPI mode-3 responder turning frames into register/stream accesses.
//           Define SPI_SLAVE_ERRCNT_EN to add the saturating err_cnt output.
// Revision: 1.0
// ============================================================================
module spi_slave_regif
    import spi_slave_pkg::*;
#(
    parameter int unsigned ADDR_W    = 6,
    parameter logic [7:0]  STATUS_ID = STATUS_ID_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_cs_n,
    input  logic              spi_sck,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [15:0]       reg_wdata,
    output logic              reg_wr_en,
    output logic              reg_rd_en,
    input  logic [15:0]       reg_rdata,
    input  logic [15:0]       rd_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    output logic              busy
`ifdef SPI_SLAVE_ERRCNT_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    logic        w_cs_sync, w_cs_rise, w_cs_fall;
    logic        w_sck_lvl_unused, w_sck_rise, w_sck_fall;
    logic        r_mosi_meta, r_mosi_sync;
    logic        r_armed;
    state_t      r_state;
    logic [3:0]  r_bit_cnt;
    logic [14:0] r_rx_sr;
    logic [15:0] r_tx_sr;

    logic [15:0] w_rx_next;
    logic [1:0]  w_opcode;
    logic        w_frame_start;
    logic        w_word_done;
    logic        w_stream_load;

    spi_sync_edge u_cs_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (spi_cs_n),
        .q    (w_cs_sync),
        .rise (w_cs_rise),
        .fall (w_cs_fall)
    );

    spi_sync_edge u_sck_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (spi_sck),
        .q    (w_sck_lvl_unused),
        .rise (w_sck_rise),
        .fall (w_sck_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
        end else begin
            r_mosi_meta <= spi_mosi;
            r_mosi_sync <= r_mosi_meta;
        end
    end

    assign w_rx_next     = {r_rx_sr, r_mosi_sync};
    assign w_opcode      = w_rx_next[15:14];
    assign w_frame_start = w_cs_fall & r_armed & ~w_cs_rise;
    assign w_word_done   = w_sck_rise & (r_state != ST_IDLE) & (r_bit_cnt == 4'd15) & ~w_cs_rise;
    assign w_stream_load = w_word_done &
                           (((r_state == ST_CMD) && (w_opcode == OP_RDDATA)) ||
                            (r_state == ST_RD_STREAM));
    assign spi_miso_oe   = r_armed & ~w_cs_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed   <= 1'b0;
            r_state   <= ST_IDLE;
            r_bit_cnt <= 4'd0;
            r_rx_sr   <= '0;
            r_tx_sr   <= '0;
            spi_miso  <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            rd_ready  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            rd_ready  <= 1'b0;
            if (w_cs_sync) begin
                r_armed <= 1'b1;
            end

            if (w_cs_rise) begin
                r_state   <= ST_IDLE;
                busy      <= 1'b0;
                r_bit_cnt <= 4'd0;
                spi_miso  <= 1'b0;
            end else if (w_frame_start) begin
                r_state   <= ST_CMD;
                busy      <= 1'b1;
                r_bit_cnt <= 4'd0;
                r_tx_sr   <= {STATUS_ID, 7'b0, rd_valid};
            end else if (r_state != ST_IDLE) begin
                if (w_sck_fall) begin
                    spi_miso <= r_tx_sr[15];
                    r_tx_sr  <= {r_tx_sr[14:0], 1'b0};
                end
                if (w_sck_rise) begin
                    r_rx_sr   <= w_rx_next[14:0];
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
                // Register read data arrives the clk after the strobe.
                if ((r_state == ST_RD_REG) && reg_rd_en) begin
                    r_tx_sr <= reg_rdata;
                end
                if (w_stream_load) begin
                    r_tx_sr  <= rd_valid ? rd_data : 16'h0000;
                    rd_ready <= rd_valid;
                end
                if (w_word_done) begin
                    case (r_state)
                        ST_CMD: begin
                            reg_addr <= w_rx_next[ADDR_W-1:0];
                            case (w_opcode)
                                OP_NOP:   r_state <= ST_DISCARD;
                                OP_WRREG: r_state <= ST_WR_DATA;
                                OP_RDREG: begin
                                    reg_rd_en <= 1'b1;
                                    r_state   <= ST_RD_REG;
                                end
                                default:  r_state <= ST_RD_STREAM;
                            endcase
                        end
                        ST_WR_DATA: begin
                            reg_wdata <= w_rx_next;
                            reg_wr_en <= 1'b1;
                            r_state   <= ST_DISCARD;
                        end
                        ST_RD_REG: begin
                            r_tx_sr <= 16'h0000;
                            r_state <= ST_DISCARD;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

`ifdef SPI_SLAVE_ERRCNT_EN
    // An underrun is charged when the master actually clocks out the zero word,
    // not when the speculative load after the final word finds the FIFO empty.
    logic r_underrun;
    logic w_err_inc;

    assign w_err_inc = (w_cs_rise && (r_state != ST_IDLE) && (r_bit_cnt != 4'd0)) ||
                       (w_stream_load && r_underrun);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_underrun <= 1'b0;
            err_cnt    <= 8'h00;
        end else begin
            if (w_cs_rise || w_frame_start) begin
                r_underrun <= 1'b0;
            end else if (w_stream_load) begin
                r_underrun <= ~rd_valid;
            end
            if (w_err_inc && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_regif.sv
`default_nettype none
// ============================================================================
// Module  : tb_spi_slave_regif
// Brief   : Directed self-checking bench for spi_slave_regif (SPI mode 3, MSB first).
// Revision: 1.0
// ============================================================================
module tb_spi_slave_regif;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        spi_cs_n, spi_sck, spi_mosi;
    logic        spi_miso, spi_miso_oe;
    logic [5:0]  reg_addr;
    logic [15:0] reg_wdata, reg_rdata, rd_data;
    logic        reg_wr_en, reg_rd_en, rd_valid, rd_ready, busy;
`ifdef SPI_SLAVE_ERRCNT_EN
    logic [7:0]  err_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Register / FIFO models and strobe monitors
    logic [15:0] fifo_mem [4];
    int          fifo_n  = 0;
    int          fifo_rd = 0;
    int          wr_cnt = 0, rd_cnt = 0, pop_cnt = 0;
    logic [15:0] last_wdata;
    logic [5:0]  last_waddr, last_raddr;

    logic [15:0] mosi_words [8];
    logic [15:0] miso_words [8];
    logic        mid_busy, mid_oe;

    always #5 clk = ~clk;

    spi_slave_regif #(.ADDR_W(6), .STATUS_ID(8'hA5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spi_cs_n   (spi_cs_n),
        .spi_sck    (spi_sck),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .spi_miso_oe(spi_miso_oe),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_wr_en  (reg_wr_en),
        .reg_rd_en  (reg_rd_en),
        .reg_rdata  (reg_rdata),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .busy       (busy)
`ifdef SPI_SLAVE_ERRCNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    assign rd_valid = (fifo_rd < fifo_n);
    assign rd_data  = rd_valid ? fifo_mem[fifo_rd[1:0]] : 16'hDEAD;

    always @(negedge clk) begin
        if (reg_wr_en) begin
            wr_cnt++;
            last_wdata = reg_wdata;
            last_waddr = reg_addr;
        end
        if (reg_rd_en) begin
            rd_cnt++;
            last_raddr = reg_addr;
        end
        if (rd_ready) begin
            pop_cnt++;
            fifo_rd++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One frame of n words; optional trailing SCK cycle; optional reset pulse at (rst_w, rst_b).
    task automatic spi_xfer(input int n, input bit extra, input int rst_w, input int rst_b);
        spi_cs_n = 1'b0;
        #100;
        for (int w = 0; w < n; w++) begin
            for (int b = 15; b >= 0; b--) begin
                spi_sck  = 1'b0;
                spi_mosi = mosi_words[w][b];
                #50;
                spi_sck = 1'b1;
                miso_words[w][b] = spi_miso;
                if (w == 0 && b == 8) begin
                    mid_busy = busy;
                    mid_oe   = spi_miso_oe;
                end
                if (w == rst_w && b == rst_b) begin
                    rst_n = 1'b0;
                    #10;
                    check("rstmid_addr", 32'(reg_addr), 32'h0);
                    check("rstmid_wdata", 32'(reg_wdata), 32'h0);
                    check("rstmid_busy", 32'(busy), 32'h0);
                    #10;
                    rst_n = 1'b1;
                    #30;
                end else begin
                    #50;
                end
            end
        end
        if (extra) begin
            spi_sck  = 1'b0;
            spi_mosi = 1'b0;
            #50;
            spi_sck = 1'b1;
            #50;
        end
        #100;
        spi_cs_n = 1'b1;
        #300;
    endtask

    int wr0, rd0, pop0;

    initial begin
        rst_n     = 1'b0;
        spi_cs_n  = 1'b1;
        spi_sck   = 1'b1;
        spi_mosi  = 1'b0;
        reg_rdata = 16'h1234;
        #50;
        check("rst_outs", {spi_miso, spi_miso_oe, reg_wr_en, reg_rd_en, rd_ready, busy}, 32'h0);
        check("rst_addr", 32'(reg_addr), 32'h0);
        check("rst_wdata", 32'(reg_wdata), 32'h0);
`ifdef SPI_SLAVE_ERRCNT_EN
        check("rst_errcnt", 32'(err_cnt), 32'h0);
`endif
        #50;
        rst_n = 1'b1;
        #200;
        check("idle_oe", 32'(spi_miso_oe), 32'h0);

        // WRREG addr 5 <= BEEF
        wr0 = wr_cnt; rd0 = rd_cnt; pop0 = pop_cnt;
        mosi_words[0] = 16'h4005; mosi_words[1] = 16'hBEEF;
        spi_xfer(2, 1'b0, -1, -1);
        check("wr_pulses", 32'(wr_cnt - wr0), 32'd1);
        check("wr_addr", 32'(last_waddr), 32'd5);
        check("wr_data", 32'(last_wdata), 32'hBEEF);
        check("wr_rdpulses", 32'(rd_cnt - rd0), 32'd0);
        check("wr_miso0", 32'(miso_words[0]), 32'hA500);
        check("wr_midbusy", 32'(mid_busy), 32'd1);
        check("wr_midoe", 32'(mid_oe), 32'd1);
        check("wr_endbusy", 32'(busy), 32'd0);

        // RDREG addr 3
        wr0 = wr_cnt; rd0 = rd_cnt;
        mosi_words[0] = 16'h8003; mosi_words[1] = 16'h0000;
        spi_xfer(2, 1'b0, -1, -1);
        check("rd_pulses", 32'(rd_cnt - rd0), 32'd1);
        check("rd_addr", 32'(last_raddr), 32'd3);
        check("rd_wrpulses", 32'(wr_cnt - wr0), 32'd0);
        check("rd_miso0", 32'(miso_words[0]), 32'hA500);
        check("rd_miso1", 32'(miso_words[1]), 32'h1234);

        // RDDATA burst with underrun on the third data word
        fifo_mem[0] = 16'h0011; fifo_mem[1] = 16'h0022;
        fifo_rd = 0; fifo_n = 2;
        pop0 = pop_cnt;
        mosi_words[0] = 16'hC000; mosi_words[1] = 16'h0000;
        mosi_words[2] = 16'h0000; mosi_words[3] = 16'h0000;
        spi_xfer(4, 1'b0, -1, -1);
        check("st_miso0", 32'(miso_words[0]), 32'hA501);
        check("st_miso1", 32'(miso_words[1]), 32'h0011);
        check("st_miso2", 32'(miso_words[2]), 32'h0022);
        check("st_miso3", 32'(miso_words[3]), 32'h0000);
        check("st_pops", 32'(pop_cnt - pop0), 32'd2);
`ifdef SPI_SLAVE_ERRCNT_EN
        check("st_errcnt", 32'(err_cnt), 32'd1);
`endif

        // WRREG command followed by a single trailing SCK cycle
        wr0 = wr_cnt;
        mosi_words[0] = 16'h4001;
        spi_xfer(1, 1'b1, -1, -1);
        check("tr_wrpulses", 32'(wr_cnt - wr0), 32'd0);
        check("tr_busy", 32'(busy), 32'd0);
        check("tr_oe", 32'(spi_miso_oe), 32'd0);
`ifdef SPI_SLAVE_ERRCNT_EN
        check("tr_errcnt", 32'(err_cnt), 32'd2);
`endif

        // Reset during bit 8 of the write data word, released with CS still low
        wr0 = wr_cnt; rd0 = rd_cnt; pop0 = pop_cnt;
        mosi_words[0] = 16'h4005; mosi_words[1] = 16'hBEEF;
        mosi_words[2] = 16'h4009; mosi_words[3] = 16'h1111;
        spi_xfer(4, 1'b0, 1, 8);
        check("rs_strobes", 32'((wr_cnt - wr0) + (rd_cnt - rd0) + (pop_cnt - pop0)), 32'd0);
        check("rs_busy", 32'(busy), 32'd0);
`ifdef SPI_SLAVE_ERRCNT_EN
        check("rs_errcnt", 32'(err_cnt), 32'd0);
`endif

        // Next full frame after the reset works normally
        wr0 = wr_cnt;
        mosi_words[0] = 16'h4007; mosi_words[1] = 16'hCAFE;
        spi_xfer(2, 1'b0, -1, -1);
        check("post_pulses", 32'(wr_cnt - wr0), 32'd1);
        check("post_addr", 32'(last_waddr), 32'd7);
        check("post_data", 32'(last_wdata), 32'hCAFE);
        check("post_miso0", 32'(miso_words[0]), 32'hA500);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
